// File: rtl/ib_fetch_sequencer.sv
// Instruction fetch sequencer: owns the PC, issues one memory read at a time, hands words to decode.
// Optional macro IB_HALT_ON_WRAP_EN: accepting the last address halts instead of wrapping the PC.
module ib_fetch_sequencer #(
  parameter int                AWIDTH     = 6,
  parameter int                RWIDTH     = 32,
  parameter int                MEM_LAT    = 1,
  parameter logic [AWIDTH-1:0] RESET_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              redirect,
  input  logic [AWIDTH-1:0] redirect_addr,
  output logic              mem_req,
  output logic [AWIDTH-1:0] mem_addr,
  input  logic [RWIDTH-1:0] mem_rdata,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [RWIDTH-1:0] instr,
  output logic [AWIDTH-1:0] instr_addr,
  output logic [AWIDTH-1:0] pc,
  output logic              halted
);

  localparam int              CW   = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CW-1:0]   LAST = CW'(MEM_LAT - 1);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, VALID, HALT} state_t;

  state_t            state, state_nx;
  logic [AWIDTH-1:0] pc_nx;
  logic [CW-1:0]     cnt;
  logic              capture;

  assign mem_addr = pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    pc_nx       = pc;
    capture     = 1'b0;
    mem_req     = 1'b0;
    instr_valid = 1'b0;
    halted      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = REQ;
          pc_nx    = RESET_ADDR;
        end
      end
      REQ: begin
        mem_req  = 1'b1;
        state_nx = WAIT;
      end
      WAIT: begin
        if (cnt == LAST) begin
          capture  = 1'b1;
          state_nx = VALID;
        end
      end
      VALID: begin
        instr_valid = 1'b1;
        if (instr_ready) begin
          pc_nx    = pc + AWIDTH'(1);
          state_nx = REQ;
`ifdef IB_HALT_ON_WRAP_EN
          if (pc == {AWIDTH{1'b1}}) state_nx = HALT;
`endif
        end
      end
      HALT: begin
`ifdef IB_HALT_ON_WRAP_EN
        halted = 1'b1;
`endif
      end
      default: state_nx = IDLE;
    endcase
    // Redirect wins in every state, including over start and over a handshake.
    if (redirect) begin
      state_nx = REQ;
      pc_nx    = redirect_addr;
      capture  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc         <= RESET_ADDR;
      cnt        <= '0;
      instr      <= '0;
      instr_addr <= '0;
    end else begin
      pc <= pc_nx;
      if (state == REQ)       cnt <= '0;
      else if (state == WAIT) cnt <= cnt + CW'(1);
      if (capture) begin
        instr      <= mem_rdata;
        instr_addr <= pc;
      end
    end
  end

endmodule

// File: tb/tb_ib_fetch_sequencer.sv
// Bench: two sequencers (MEM_LAT 1 and 3) share stimulus; each is checked every cycle against a fetch-age model.
module tb_ib_fetch_sequencer;
  localparam int AW  = 6;
  localparam int RW  = 32;
  localparam int ML0 = 1;
  localparam int ML1 = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          start, redirect, instr_ready;
  logic [AW-1:0] redirect_addr;
  logic          mem_req     [2];
  logic [AW-1:0] mem_addr    [2];
  logic [RW-1:0] mem_rdata   [2];
  logic          instr_valid [2];
  logic [RW-1:0] instr       [2];
  logic [AW-1:0] instr_addr  [2];
  logic [AW-1:0] pc          [2];
  logic          halted      [2];

  always #5 clk = ~clk;

  ib_fetch_sequencer #(.AWIDTH(AW), .RWIDTH(RW), .MEM_LAT(ML0), .RESET_ADDR(6'd0)) u_dut0 (
    .clk(clk), .rst(rst), .start(start), .redirect(redirect), .redirect_addr(redirect_addr),
    .mem_req(mem_req[0]), .mem_addr(mem_addr[0]), .mem_rdata(mem_rdata[0]),
    .instr_valid(instr_valid[0]), .instr_ready(instr_ready), .instr(instr[0]),
    .instr_addr(instr_addr[0]), .pc(pc[0]), .halted(halted[0]));

  ib_fetch_sequencer #(.AWIDTH(AW), .RWIDTH(RW), .MEM_LAT(ML1), .RESET_ADDR(6'd0)) u_dut1 (
    .clk(clk), .rst(rst), .start(start), .redirect(redirect), .redirect_addr(redirect_addr),
    .mem_req(mem_req[1]), .mem_addr(mem_addr[1]), .mem_rdata(mem_rdata[1]),
    .instr_valid(instr_valid[1]), .instr_ready(instr_ready), .instr(instr[1]),
    .instr_addr(instr_addr[1]), .pc(pc[1]), .halted(halted[1]));

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int ml [2] = '{ML0, ML1};

  // Reference model: age counts cycles since the request; valid once age reaches MEM_LAT+1.
  bit            m_run  [2];
  bit            m_halt [2];
  int            m_age  [2];
  logic [AW-1:0] m_pc   [2];
  logic [AW-1:0] m_iaddr[2];
  logic [RW-1:0] m_instr[2];

  bit            hreq  [2][16];
  logic [AW-1:0] haddr [2][16];

  function automatic logic [RW-1:0] mem_word(input logic [AW-1:0] a);
    return 32'h100 + 32'(a);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_run[d] = 0; m_halt[d] = 0; m_age[d] = 0;
      m_pc[d] = '0; m_iaddr[d] = '0; m_instr[d] = '0;
    end
  endtask

  task automatic model_edge();
    for (int d = 0; d < 2; d++) begin
      bit wrap_halt;
      wrap_halt = 0;
      if (redirect) begin
        m_run[d] = 1; m_halt[d] = 0; m_pc[d] = redirect_addr; m_age[d] = 0;
      end else if (!m_run[d]) begin
        if (!m_halt[d] && start) begin
          m_run[d] = 1; m_pc[d] = '0; m_age[d] = 0;
        end
      end else if (m_age[d] <= ml[d]) begin
        if (m_age[d] == ml[d]) begin
          m_instr[d] = mem_word(m_pc[d]);
          m_iaddr[d] = m_pc[d];
        end
        m_age[d]++;
      end else if (instr_ready) begin
`ifdef IB_HALT_ON_WRAP_EN
        wrap_halt = (int'(m_pc[d]) == (1 << AW) - 1);
`endif
        if (wrap_halt) begin
          m_run[d] = 0; m_halt[d] = 1; m_pc[d] = '0;
        end else begin
          m_pc[d]  = AW'((int'(m_pc[d]) + 1) % (1 << AW));
          m_age[d] = 0;
        end
      end
    end
  endtask

  // Memory returns address+0x100 exactly MEM_LAT cycles after a request, junk otherwise.
  task automatic mem_update();
    for (int d = 0; d < 2; d++) begin
      int k;
      hreq[d][cyc % 16]  = mem_req[d];
      haddr[d][cyc % 16] = mem_addr[d];
      k = (cyc - ml[d] + 16) % 16;
      if (cyc >= ml[d] && hreq[d][k]) mem_rdata[d] = mem_word(haddr[d][k]);
      else                            mem_rdata[d] = $urandom();
    end
  endtask

  task automatic check_all();
    for (int d = 0; d < 2; d++) begin
      bit ev, er;
      er = m_run[d] && (m_age[d] == 0);
      ev = m_run[d] && (m_age[d] == ml[d] + 1);
      chk($sformatf("ctrl%0d_cyc%0d", d, cyc),
          64'({mem_req[d], instr_valid[d], halted[d], pc[d], mem_addr[d]}),
          64'({er, ev, m_halt[d], m_pc[d], m_pc[d]}));
      if (ev) chk($sformatf("data%0d_cyc%0d", d, cyc),
                  64'({instr_addr[d], instr[d]}), 64'({m_iaddr[d], m_instr[d]}));
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    cyc++;
    mem_update();
    check_all();
  endtask

  task automatic wait_valid(input int d, input int budget, input string name);
    int n;
    n = 0;
    while (!instr_valid[d] && n < budget) begin
      step();
      n++;
    end
    chk(name, 64'(instr_valid[d]), 64'd1);
  endtask

  task automatic check_reset_vals(input string name);
    for (int d = 0; d < 2; d++)
      chk($sformatf("%s%0d", name, d),
          64'({mem_req[d], instr_valid[d], halted[d], pc[d], mem_addr[d], instr_addr[d], instr[d]}),
          64'd0);
  endtask

  typedef struct {
    bit start;
    bit ready;
    bit req;
    int addr;
    bit valid;
    int word;
  } vec_t;

  vec_t tbl [19];

  initial begin
    // Cycle-by-cycle expectations for the MEM_LAT=1 sequencer after start, incl. 5 stall cycles.
    tbl[0]  = '{1, 1, 0, 0, 0, 0};
    tbl[1]  = '{0, 1, 1, 0, 0, 0};
    tbl[2]  = '{0, 1, 0, 0, 0, 0};
    tbl[3]  = '{0, 1, 0, 0, 1, 'h100};
    tbl[4]  = '{0, 1, 1, 1, 0, 0};
    tbl[5]  = '{0, 1, 0, 1, 0, 0};
    tbl[6]  = '{0, 1, 0, 1, 1, 'h101};
    tbl[7]  = '{0, 1, 1, 2, 0, 0};
    tbl[8]  = '{0, 1, 0, 2, 0, 0};
    tbl[9]  = '{0, 1, 0, 2, 1, 'h102};
    tbl[10] = '{0, 1, 1, 3, 0, 0};
    tbl[11] = '{0, 0, 0, 3, 0, 0};
    for (int i = 12; i <= 16; i++) tbl[i] = '{0, 0, 0, 3, 1, 'h103};
    tbl[17] = '{0, 1, 0, 3, 1, 'h103};
    tbl[18] = '{0, 1, 1, 4, 0, 0};

    rst = 1'b1; start = 0; redirect = 0; instr_ready = 0; redirect_addr = '0;
    mem_rdata[0] = '0; mem_rdata[1] = '0;
    model_reset();
    #6;
    check_reset_vals("reset_state");
    rst = 1'b0;
    mem_update();

    for (int i = 0; i < 19; i++) begin
      start = tbl[i].start; instr_ready = tbl[i].ready; redirect = 0;
      chk($sformatf("tbl_ctrl_%0d", i),
          64'({mem_req[0], mem_addr[0], instr_valid[0]}),
          64'({tbl[i].req, AW'(tbl[i].addr), tbl[i].valid}));
      if (tbl[i].valid)
        chk($sformatf("tbl_data_%0d", i), 64'({instr_addr[0], instr[0]}),
            64'({AW'(tbl[i].addr), RW'(tbl[i].word)}));
      step();
    end
    start = 0;

    // Redirect during WAIT on the MEM_LAT=3 sequencer: stale word must not surface.
    redirect = 1; redirect_addr = 6'h08; instr_ready = 0; step();
    redirect = 0; step(); step();
    redirect = 1; redirect_addr = 6'h20; step();
    redirect = 0;
    wait_valid(1, 20, "redir_wait_valid");
    chk("redir_wait_addr", 64'(instr_addr[1]), 64'h20);
    chk("redir_wait_word", 64'(instr[1]), 64'h120);

    // Redirect coinciding with a handshake at pc=5.
    redirect = 1; redirect_addr = 6'h05; step();
    redirect = 0;
    wait_valid(0, 10, "hs_redir_valid");
    chk("hs_redir_pc5", 64'(instr_addr[0]), 64'h05);
    instr_ready = 1; redirect = 1; redirect_addr = 6'h10; step();
    redirect = 0; instr_ready = 0;
    chk("hs_redir_target", 64'({mem_req[0], mem_addr[0]}), 64'({1'b1, 6'h10}));

    // Wrap at the top of the address space.
    redirect = 1; redirect_addr = 6'h3E; instr_ready = 1; step();
    redirect = 0;
    for (int i = 1; i <= 10; i++) begin
      step();
      for (int d = 0; d < 2; d++)
        if (i == 2 * (ml[d] + 2)) begin
`ifdef IB_HALT_ON_WRAP_EN
          chk($sformatf("wrap_halt%0d", d), 64'({halted[d], mem_req[d], pc[d]}), 64'({1'b1, 1'b0, 6'h00}));
`else
          chk($sformatf("wrap_cont%0d", d), 64'({halted[d], mem_req[d], mem_addr[d]}), 64'({1'b0, 1'b1, 6'h00}));
`endif
        end
    end
    start = 1; step();
    start = 0; step();
    redirect = 1; redirect_addr = 6'h04; step();
    redirect = 0;
    for (int d = 0; d < 2; d++)
      chk($sformatf("resume%0d", d), 64'({halted[d], mem_req[d], mem_addr[d]}), 64'({1'b0, 1'b1, 6'h04}));

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      redirect      = ($urandom_range(0, 19) == 0);
      redirect_addr = ($urandom_range(0, 2) == 0) ? AW'(6'h3E + $urandom_range(0, 1)) : AW'($urandom());
      start         = ($urandom_range(0, 9) == 0);
      instr_ready   = ($urandom_range(0, 2) != 0);
      step();
    end
    start = 0; redirect = 0; instr_ready = 0;

    // Asynchronous reset mid-fetch: outputs clear in the same cycle, then stay idle.
    redirect = 1; redirect_addr = 6'h11; step();
    redirect = 0; step();
    #3;
    rst = 1'b1;
    model_reset();
    #1;
    check_reset_vals("reset_midfetch");
    #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) step();
    start = 1; step();
    start = 0;
    for (int d = 0; d < 2; d++)
      chk($sformatf("restart%0d", d), 64'({mem_req[d], mem_addr[d]}), 64'({1'b1, 6'h00}));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
